// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default geometry, log2/power-of-two functions and the
// derived pointer widths used by the downsizing FIFO.
package fifo_pkg;

    localparam int DEF_DATAIN_WIDTH  = 32;
    localparam int DEF_DATAOUT_WIDTH = 16;
    localparam int DEF_FIFO_DEPTH    = 16;

    function automatic int log2_ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic int width_ratio(input int din, input int dout);
        return din / dout;
    endfunction

    function automatic int ratio_bit(input int din, input int dout);
        return log2_ceil(width_ratio(din, dout));
    endfunction

    function automatic int depth_bit(input int depth);
        return log2_ceil(depth);
    endfunction

    // Legal when the wide word splits into a power-of-two count of whole slices.
    function automatic bit ratio_ok(input int din, input int dout);
        return (dout > 0) && (din >= dout) && ((din % dout) == 0) && is_pow2(din / dout);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && is_pow2(depth);
    endfunction

endpackage

// File: rtl/sync_fifo_ds_ram.sv
// Single-clock simple dual-port RAM holding wide FIFO words:
// synchronous write, asynchronous read of a whole word.
module sync_fifo_ds_ram #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_downsize.sv
// Single-clock FIFO taking DATAIN_WIDTH words and returning DATAOUT_WIDTH slices,
// least-significant slice first. Define SYNC_FIFO_DS_ERR_EN for sticky error flags.
module sync_fifo_downsize
    import fifo_pkg::*;
#(
    parameter int DATAIN_WIDTH  = DEF_DATAIN_WIDTH,
    parameter int DATAOUT_WIDTH = DEF_DATAOUT_WIDTH,
    parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [DATAIN_WIDTH-1:0]  data_write,
    input  logic                     r_en,
    output logic [DATAOUT_WIDTH-1:0] data_read,
    output logic                     flag_full,
    output logic                     flag_empty,
    output logic [depth_bit(FIFO_DEPTH)+ratio_bit(DATAIN_WIDTH, DATAOUT_WIDTH):0] fill_level
`ifdef SYNC_FIFO_DS_ERR_EN
    ,
    output logic                     err_overflow,
    output logic                     err_underflow
`endif
);

    localparam int RATIO          = width_ratio(DATAIN_WIDTH, DATAOUT_WIDTH);
    localparam int RATIO_BIT      = ratio_bit(DATAIN_WIDTH, DATAOUT_WIDTH);
    localparam int FIFO_DEPTH_BIT = depth_bit(FIFO_DEPTH);
    localparam int PTR_W          = FIFO_DEPTH_BIT + RATIO_BIT + 1;

    localparam logic [FIFO_DEPTH_BIT:0] WPTR_ONE   = 1;
    localparam logic [PTR_W-1:0]        RPTR_ONE   = 1;
    localparam logic [FIFO_DEPTH_BIT:0] FULL_WORDS = FIFO_DEPTH;

    if (!ratio_ok(DATAIN_WIDTH, DATAOUT_WIDTH)) begin : g_bad_ratio
        $error("sync_fifo_downsize: DATAIN_WIDTH/DATAOUT_WIDTH must be an integer power of 2");
    end
    if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
        $error("sync_fifo_downsize: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    // Write pointer counts wide words, read pointer counts slices; both carry a wrap bit.
    logic [FIFO_DEPTH_BIT:0]   wptr;
    logic [PTR_W-1:0]          rptr;
    logic [FIFO_DEPTH_BIT:0]   rptr_words;
    logic [FIFO_DEPTH_BIT-1:0] rd_addr;
    logic [PTR_W-1:0]          wptr_slices;
    logic [DATAIN_WIDTH-1:0]   rd_word;
    logic [DATAOUT_WIDTH-1:0]  rd_slice;
    logic                      wr_accept;
    logic                      rd_accept;

    // Request/accept: a write is taken on a rising edge when w_en is high and flag_full is
    // low; a read likewise with r_en and flag_empty. A refused request leaves all state as is.
    assign wr_accept = w_en && !flag_full;
    assign rd_accept = r_en && !flag_empty;

    assign rptr_words  = rptr[PTR_W-1 -: FIFO_DEPTH_BIT+1];
    assign rd_addr     = rptr[RATIO_BIT +: FIFO_DEPTH_BIT];
    assign wptr_slices = PTR_W'(wptr) << RATIO_BIT;

    assign fill_level = wptr_slices - rptr;
    assign flag_empty = (fill_level == '0);
    // A wide entry is only released once its last slice has been consumed.
    assign flag_full  = ((wptr - rptr_words) == FULL_WORDS);

    sync_fifo_ds_ram #(
        .WIDTH (DATAIN_WIDTH),
        .AW    (FIFO_DEPTH_BIT)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wptr[FIFO_DEPTH_BIT-1:0]),
        .wdata (data_write),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    if (RATIO_BIT == 0) begin : g_no_slice
        assign rd_slice = rd_word;
    end else begin : g_slice
        logic [RATIO-1:0][DATAOUT_WIDTH-1:0] slices;
        logic [RATIO_BIT-1:0]                slice_idx;
        assign slices    = rd_word;
        assign slice_idx = rptr[RATIO_BIT-1:0];
        assign rd_slice  = slices[slice_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            data_read <= '0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + WPTR_ONE;
            end
            if (rd_accept) begin
                rptr      <= rptr + RPTR_ONE;
                data_read <= rd_slice;
            end
        end
    end

`ifdef SYNC_FIFO_DS_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (w_en && flag_full) begin
                err_overflow <= 1'b1;
            end
            if (r_en && flag_empty) begin
                err_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_downsize.sv
// Bench for sync_fifo_downsize (32->16 bits, depth 4): slice-queue model checked every
// cycle, plus literal expectations for reset, ordering, full/empty and reset mid-stream.
module tb_sync_fifo_downsize;

    localparam int DIN   = 32;
    localparam int DOUT  = 16;
    localparam int DEPTH = 4;
    localparam int RATIO = DIN / DOUT;
    localparam int FW    = $clog2(DEPTH) + $clog2(RATIO) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            w_en = 1'b0;
    logic            r_en = 1'b0;
    logic [DIN-1:0]  data_write = '0;
    logic [DOUT-1:0] data_read;
    logic            flag_full;
    logic            flag_empty;
    logic [FW-1:0]   fill_level;
`ifdef SYNC_FIFO_DS_ERR_EN
    logic            err_overflow;
    logic            err_underflow;
`endif

    sync_fifo_downsize #(
        .DATAIN_WIDTH  (DIN),
        .DATAOUT_WIDTH (DOUT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .w_en          (w_en),
        .data_write    (data_write),
        .r_en          (r_en),
        .data_read     (data_read),
        .flag_full     (flag_full),
        .flag_empty    (flag_empty),
        .fill_level    (fill_level)
`ifdef SYNC_FIFO_DS_ERR_EN
        ,
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
`endif
    );

    // Clock and bookkeeping
    always #5 clk = ~clk;

    int              n_checks = 0;
    int              n_errors = 0;
    int              reads_done = 0;
    bit              chk_en = 1'b0;

    // Model: the unread slices in the order they must emerge
    logic [DOUT-1:0] exp_q[$];
    logic [DOUT-1:0] m_data = '0;
    bit              m_ovf = 1'b0;
    bit              m_unf = 1'b0;

    function automatic bit m_empty();
        return exp_q.size() == 0;
    endfunction

    // Wide entries held = unread slices rounded up to whole words.
    function automatic bit m_full();
        return ((exp_q.size() + RATIO - 1) / RATIO) == DEPTH;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: one clock of requests, then the model absorbs what was accepted.
    task automatic step(input bit w, input bit r, input logic [DIN-1:0] d);
        bit wa, ra, ovf, unf;
        wa  = w && !m_full();
        ra  = r && !m_empty();
        ovf = w && m_full();
        unf = r && m_empty();
        w_en = w;
        r_en = r;
        data_write = d;
        @(posedge clk);
        #1;
        if (ovf) m_ovf = 1'b1;
        if (unf) m_unf = 1'b1;
        if (ra) begin
            m_data = exp_q.pop_front();
            reads_done++;
        end
        if (wa) begin
            for (int k = 0; k < RATIO; k++) begin
                exp_q.push_back(d[k*DOUT +: DOUT]);
            end
        end
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        w_en = 1'b0;
        r_en = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_data = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        rst    = 1'b0;
    endtask

    // Scoreboard compare on the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("data_read", 32'(data_read), 32'(m_data));
            check("flag_empty", 32'(flag_empty), 32'(m_empty()));
            check("flag_full", 32'(flag_full), 32'(m_full()));
            check("fill_level", 32'(fill_level), 32'(exp_q.size()));
`ifdef SYNC_FIFO_DS_ERR_EN
            check("err_overflow", 32'(err_overflow), 32'(m_ovf));
            check("err_underflow", 32'(err_underflow), 32'(m_unf));
`endif
        end
    end

    initial begin
        int writes;
        bit w, r;
        logic [DIN-1:0] d;

        // 1: reset values
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_read", 32'(data_read), 32'h0);
        check("rst_empty", 32'(flag_empty), 32'h1);
        check("rst_full", 32'(flag_full), 32'h0);
        check("rst_fill", 32'(fill_level), 32'h0);
`ifdef SYNC_FIFO_DS_ERR_EN
        check("rst_err_ovf", 32'(err_overflow), 32'h0);
        check("rst_err_unf", 32'(err_underflow), 32'h0);
`endif
        rst = 1'b0;
        chk_en = 1'b1;

        // 2: one word comes back low slice first
        step(1'b1, 1'b0, 32'hAAAA_5555);
        check("t2_fill", 32'(fill_level), 32'd2);
        step(1'b0, 1'b1, '0);
        check("t2_slice0", 32'(data_read), 32'h5555);
        step(1'b0, 1'b1, '0);
        check("t2_slice1", 32'(data_read), 32'hAAAA);
        check("t2_empty", 32'(flag_empty), 32'h1);
        check("t2_fill_end", 32'(fill_level), 32'd0);

        // 3: full, overflow, entry frees only after its second slice
        step(1'b1, 1'b0, 32'h0101_1010);
        step(1'b1, 1'b0, 32'h0202_2020);
        step(1'b1, 1'b0, 32'h0303_3030);
        step(1'b1, 1'b0, 32'h0404_4040);
        check("t3_full", 32'(flag_full), 32'h1);
        check("t3_fill", 32'(fill_level), 32'd8);
        step(1'b1, 1'b0, 32'hDEAD_BEEF);
        check("t3_fill_after_ovf", 32'(fill_level), 32'd8);
`ifdef SYNC_FIFO_DS_ERR_EN
        check("t3_err_ovf", 32'(err_overflow), 32'h1);
`endif
        step(1'b0, 1'b1, '0);
        check("t3_still_full", 32'(flag_full), 32'h1);
        check("t3_fill7", 32'(fill_level), 32'd7);
        check("t3_first_slice", 32'(data_read), 32'h1010);
        step(1'b0, 1'b1, '0);
        check("t3_not_full", 32'(flag_full), 32'h0);
        repeat (6) step(1'b0, 1'b1, '0);
        check("t3_last_slice", 32'(data_read), 32'h0404);

        // 4: write and read on empty FIFO, read refused
        step(1'b1, 1'b1, 32'h5A5A_C3C3);
        check("t4_data_hold", 32'(data_read), 32'h0404);
        check("t4_fill", 32'(fill_level), 32'd2);
`ifdef SYNC_FIFO_DS_ERR_EN
        check("t4_err_unf", 32'(err_underflow), 32'h1);
`endif
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        check("t4_slice1", 32'(data_read), 32'h5A5A);

        // 5: random stream of 20 words across pointer wraps
        writes = 0;
        reads_done = 0;
        for (int cyc = 0; cyc < 2000 && !(writes == 20 && exp_q.size() == 0); cyc++) begin
            w = (writes < 20) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0);
            d = $urandom;
            if (w && !m_full()) writes++;
            step(w, r, d);
        end
        check("t5_words_written", 32'(writes), 32'd20);
        check("t5_slices_read", 32'(reads_done), 32'd40);

        // 6: reset while holding data
        step(1'b1, 1'b0, 32'h1111_2222);
        step(1'b1, 1'b0, 32'h3333_4444);
        step(1'b1, 1'b0, 32'h5555_6666);
        check("t6_fill_before", 32'(fill_level), 32'd6);
        do_reset();
        check("t6_fill", 32'(fill_level), 32'd0);
        check("t6_empty", 32'(flag_empty), 32'h1);
        check("t6_full", 32'(flag_full), 32'h0);
        check("t6_data_read", 32'(data_read), 32'h0);
        step(1'b0, 1'b1, '0);
        check("t6_read_refused", 32'(data_read), 32'h0);
        check("t6_fill_after_read", 32'(fill_level), 32'd0);
`ifdef SYNC_FIFO_DS_ERR_EN
        check("t6_err_unf", 32'(err_underflow), 32'h1);
        check("t6_err_ovf", 32'(err_overflow), 32'h0);
`endif
        step(1'b1, 1'b0, 32'h1234_5678);
        step(1'b0, 1'b1, '0);
        check("t6_after_reset", 32'(data_read), 32'h5678);

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
